// File: rtl/mcp_share_arbiter.sv
// Round-robin owner of one shared multicycle datapath: launches an operand, times the
// capture enable MCP_CYCLES clocks later, and returns the result with a done pulse.
module mcp_share_arbiter #(
  parameter int NREQ       = 4,
  parameter int DW         = 8,
  parameter int MCP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              src_en,
  output logic [DW-1:0]     src_data,
  output logic              cap_en,
  input  logic [DW-1:0]     res_in,
  output logic [DW-1:0]     res_out,
  output logic [NREQ-1:0]   done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MCP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [PW-1:0]   ptr_reg, ptr_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [NREQ-1:0] gnt_reg, gnt_next;
  logic [NREQ-1:0] done_reg, done_next;
  logic            busy_reg, busy_next;
  logic            src_en_reg, src_en_next;
  logic            cap_en_reg, cap_en_next;
  logic [DW-1:0]   src_data_reg, src_data_next;
  logic [DW-1:0]   res_out_reg, res_out_next;

  logic [DW-1:0]   operand  [NREQ];
  logic [PW-1:0]   cand_idx [NREQ];
  logic [NREQ-1:0] cand_hit;
  logic            found;
  logic [PW-1:0]   win_idx;
  logic [PW-1:0]   win_inc;

  // Candidate gi is the requester gi positions after the pointer, wrapped mod NREQ.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
      logic [PW:0] sum;
      assign operand[gi]  = req_data[gi*DW +: DW];
      assign sum          = {1'b0, ptr_reg} + (PW+1)'(gi);
      assign cand_idx[gi] = (sum >= (PW+1)'(NREQ)) ? PW'(sum - (PW+1)'(NREQ)) : PW'(sum);
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // Lowest candidate offset wins; scanning downward leaves it as the final assignment.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        found   = 1'b1;
        win_idx = cand_idx[k];
      end
    end
  end

  assign win_inc = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    cnt_next      = cnt_reg;
    gnt_next      = gnt_reg;
    busy_next     = busy_reg;
    src_en_next   = 1'b0;
    cap_en_next   = 1'b0;
    done_next     = '0;
    src_data_next = src_data_reg;
    res_out_next  = res_out_reg;
    case (state_reg)
      S_IDLE: begin
        if (found) begin
          state_next    = S_LAUNCH;
          ptr_next      = win_inc;
          gnt_next      = NREQ'(1) << win_idx;
          busy_next     = 1'b1;
          src_en_next   = 1'b1;
          src_data_next = operand[win_idx];
        end
      end
      S_LAUNCH: begin
        state_next = S_WAIT;
        cnt_next   = CW'(1);
      end
      S_WAIT: begin
        // Launch cycle plus MCP_CYCLES-1 wait cycles puts capture exactly MCP_CYCLES later.
        if (cnt_reg == CW'(MCP_CYCLES - 1)) begin
          state_next  = S_CAPTURE;
          cnt_next    = '0;
          cap_en_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_CAPTURE: begin
        state_next = S_DONE;
      end
      S_DONE: begin
        state_next   = S_IDLE;
        res_out_next = res_in;
        done_next    = gnt_reg;
        gnt_next     = '0;
        busy_next    = 1'b0;
      end
      default: begin
        state_next = S_IDLE;
        gnt_next   = '0;
        busy_next  = 1'b0;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      ptr_reg      <= '0;
      cnt_reg      <= '0;
      gnt_reg      <= '0;
      busy_reg     <= 1'b0;
      src_en_reg   <= 1'b0;
      cap_en_reg   <= 1'b0;
      done_reg     <= '0;
      src_data_reg <= '0;
      res_out_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      cnt_reg      <= cnt_next;
      gnt_reg      <= gnt_next;
      busy_reg     <= busy_next;
      src_en_reg   <= src_en_next;
      cap_en_reg   <= cap_en_next;
      done_reg     <= done_next;
      src_data_reg <= src_data_next;
      res_out_reg  <= res_out_next;
    end
  end

  assign gnt      = gnt_reg;
  assign busy     = busy_reg;
  assign src_en   = src_en_reg;
  assign cap_en   = cap_en_reg;
  assign done     = done_reg;
  assign src_data = src_data_reg;
  assign res_out  = res_out_reg;

endmodule
